// File: rtl/csb_seq.sv
// Command sequencer: collects 5-word commands, fills a KSIZE x KSIZE operand window and
// drives one of N_ENG engines per command. Optional WAIT-cycle counter under CSB_PERF_CNT_EN.
module csb_seq #(
  parameter int              DW    = 16,
  parameter int              KSIZE = 3,
  parameter int              N_ENG = 4,
  parameter logic [N_ENG-1:0] WMASK = 4'b0011
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_en,
  input  logic [7:0]             cmd_count,
  input  logic [2*DW-1:0]        cmd,
  input  logic                   cmd_fifo_empty,
  output logic                   cmd_fifo_rd_en,
  input  logic [2*DW-1:0]        data,
  input  logic                   data_fifo_empty,
  output logic                   data_fifo_rd_en,
  input  logic [2*DW-1:0]        weight,
  input  logic                   weight_fifo_empty,
  output logic                   weight_fifo_rd_en,
  output logic [KSIZE*KSIZE*DW-1:0] win_data,
  output logic [KSIZE*KSIZE*DW-1:0] win_weight,
  output logic [DW-1:0]          win_bias,
  output logic [7:0]             op_type_o,
  output logic [7:0]             stride_1,
  output logic [15:0]            stride_2,
  output logic [15:0]            ich_size,
  output logic [15:0]            och_size,
  output logic [31:0]            weight_addr,
  output logic [31:0]            data_addr,
  output logic [31:0]            wb_addr,
  output logic [N_ENG-1:0]       eng_start,
  input  logic [N_ENG-1:0]       eng_done,
  output logic                   busy,
  output logic                   irq,
  output logic                   err,
  output logic [31:0]            perf_cycles
);

  localparam int NE = KSIZE * KSIZE;
  localparam int ND = (NE + 1) / 2;
  localparam int NW = ND + 1;
  localparam int CW = $clog2(NW + 1);
  localparam int EW = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e               state_q;
  logic [2:0]           widx_q;
  logic [7:0]           op_q, stride1_q;
  logic [15:0]          stride2_q, ich_q, och_q;
  logic [31:0]          waddr_q, daddr_q, wbaddr_q;
  logic [DW-1:0]        wd_q [NE];
  logic [DW-1:0]        ww_q [NE];
  logic [DW-1:0]        bias_q;
  logic [CW-1:0]        dcnt_q, wcnt_q, dcnt_d, wcnt_d;
  logic [7:0]           exec_q, cnt_q, exec_d;
  logic                 busy_q, irq_q, err_q;
  logic [N_ENG-1:0]     start_q;

  logic [N_ENG-1:0]     op_hot;
  logic                 op_ok, wload, done_hit, load_done;
  logic                 cmd_pop, data_pop, wt_pop;
  logic [EW-1:0]        d_lo, d_hi, w_lo, w_hi;
  logic                 d_hi_ok, w_hi_ok;

  always_comb begin
    op_hot = '0;
    for (int k = 0; k < N_ENG; k++) op_hot[k] = (op_q == 8'(k + 1));
  end

  assign op_ok    = |op_hot;
  assign wload    = |(op_hot & WMASK);
  assign done_hit = |(eng_done & op_hot);

  // FIFO pops are combinational so a word is taken in the same cycle it is seen non-empty.
  assign cmd_pop  = rst_n && (state_q == S_COLLECT) && !cmd_fifo_empty;
  assign data_pop = rst_n && (state_q == S_LOAD) && (dcnt_q != CW'(ND)) && !data_fifo_empty;
  assign wt_pop   = rst_n && (state_q == S_LOAD) && wload && (wcnt_q != CW'(NW)) && !weight_fifo_empty;

  assign dcnt_d    = dcnt_q + CW'(data_pop);
  assign wcnt_d    = wcnt_q + CW'(wt_pop);
  assign load_done = (dcnt_d == CW'(ND)) && (!wload || (wcnt_d == CW'(NW)));
  assign exec_d    = exec_q + 8'd1;

  assign d_lo    = EW'(2 * int'(dcnt_q));
  assign d_hi    = EW'(2 * int'(dcnt_q) + 1);
  assign d_hi_ok = (2 * int'(dcnt_q) + 1) < NE;
  assign w_lo    = EW'(2 * int'(wcnt_q));
  assign w_hi    = EW'(2 * int'(wcnt_q) + 1);
  assign w_hi_ok = (2 * int'(wcnt_q) + 1) < NE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      widx_q    <= '0;
      op_q      <= '0;
      stride1_q <= '0;
      stride2_q <= '0;
      ich_q     <= '0;
      och_q     <= '0;
      waddr_q   <= '0;
      daddr_q   <= '0;
      wbaddr_q  <= '0;
      for (int i = 0; i < NE; i++) begin
        wd_q[i] <= '0;
        ww_q[i] <= '0;
      end
      bias_q    <= '0;
      dcnt_q    <= '0;
      wcnt_q    <= '0;
      exec_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= '0;
    end else begin
      start_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (op_en) begin
            exec_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= cmd_count;
            widx_q <= '0;
            if (cmd_count == 8'd0) begin
              state_q <= S_DONE;
              irq_q   <= 1'b1;
            end else begin
              state_q <= S_COLLECT;
              busy_q  <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (cmd_pop) begin
            unique case (widx_q)
              3'd0: begin
                op_q      <= cmd[7:0];
                stride1_q <= cmd[15:8];
                stride2_q <= cmd[31:16];
              end
              3'd1: begin
                ich_q <= cmd[15:0];
                och_q <= cmd[31:16];
              end
              3'd2:    waddr_q  <= cmd;
              3'd3:    daddr_q  <= cmd;
              default: wbaddr_q <= cmd;
            endcase
            widx_q <= widx_q + 3'd1;
            if (widx_q == 3'd4) begin
              widx_q <= '0;
              if (op_ok) begin
                state_q <= S_LOAD;
                dcnt_q  <= '0;
                wcnt_q  <= '0;
              end else begin
                // NOP or unknown op: retire immediately without touching the operand FIFOs.
                if (op_q != 8'd0) err_q <= 1'b1;
                exec_q <= exec_d;
                if (exec_d == cnt_q) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  irq_q   <= 1'b1;
                end
              end
            end
          end
        end
        S_LOAD: begin
          if (data_pop) begin
            wd_q[d_lo] <= data[DW-1:0];
            if (d_hi_ok) wd_q[d_hi] <= data[2*DW-1:DW];
          end
          if (wt_pop) begin
            if (wcnt_q == CW'(ND)) begin
              bias_q <= weight[DW-1:0];
            end else begin
              ww_q[w_lo] <= weight[DW-1:0];
              if (w_hi_ok) ww_q[w_hi] <= weight[2*DW-1:DW];
            end
          end
          dcnt_q <= dcnt_d;
          wcnt_q <= wcnt_d;
          if (load_done) begin
            state_q <= S_ISSUE;
            start_q <= op_hot;
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (done_hit) begin
            exec_q <= exec_d;
            if (exec_d == cnt_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              irq_q   <= 1'b1;
            end else begin
              state_q <= S_COLLECT;
            end
          end
        end
        S_DONE: begin
          if (!op_en) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CSB_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && op_en) begin
      perf_q <= '0;
    end else if (state_q == S_WAIT && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  for (genvar i = 0; i < NE; i++) begin : g_win
    assign win_data[i*DW +: DW]   = wd_q[i];
    assign win_weight[i*DW +: DW] = ww_q[i];
  end

  assign cmd_fifo_rd_en    = cmd_pop;
  assign data_fifo_rd_en   = data_pop;
  assign weight_fifo_rd_en = wt_pop;
  assign win_bias    = bias_q;
  assign op_type_o   = op_q;
  assign stride_1    = stride1_q;
  assign stride_2    = stride2_q;
  assign ich_size    = ich_q;
  assign och_size    = och_q;
  assign weight_addr = waddr_q;
  assign data_addr   = daddr_q;
  assign wb_addr     = wbaddr_q;
  assign eng_start   = start_q;
  assign busy        = busy_q;
  assign irq         = irq_q;
  assign err         = err_q;

endmodule
